dpwm_period_ctrl: RTL and testbench

DPWM_PERIOD_CTRL -- requirements
Module: dpwm_period_ctrl

---
 rtl/dpwm_period_ctrl_pkg.sv | 12 +
 rtl/dpwm_duty_shadow.sv | 68 ++++++
 rtl/dpwm_period_ctrl.sv | 103 ++++++++++
 tb/tb_dpwm_period_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dpwm_period_ctrl_pkg.sv
// Shared definitions for the DPWM period controller: FSM state encoding and default duty-word geometry.
package dpwm_period_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_DE_BITS   = 6;
    localparam int DEF_DC_LENGTH = 13;

endpackage

// File: rtl/dpwm_duty_shadow.sv
// Shadow/active duty register pair with valid/ready intake; optional clamp under DPWM_DUTY_CLAMP_EN.
// Handshake: a word transfers on the edge where dc_valid && dc_ready; dc_ready stays low until that word is applied.
module dpwm_duty_shadow
    import dpwm_period_ctrl_pkg::*;
#(
    parameter int DE_bits      = DEF_DE_BITS,
    parameter int Dc_length    = DEF_DC_LENGTH,
    parameter int Count_length = Dc_length - DE_bits
) (
    input  logic                    clk_base,
    input  logic                    rst,
    input  logic [Dc_length-1:0]    Dc_in,
    input  logic                    dc_valid,
    output logic                    dc_ready,
    input  logic                    load,
    input  logic [Count_length-1:0] period_next,
    output logic [Count_length-1:0] Dc_coarse,
    output logic [DE_bits-1:0]      Dc_fine
);

    logic [Dc_length-1:0]    shadow;
    logic [Count_length-1:0] ld_coarse;
    logic [DE_bits-1:0]      ld_fine;

`ifdef DPWM_DUTY_CLAMP_EN
    localparam logic [Count_length:0] WIDE_ONE = (Count_length+1)'(1);
    logic [Count_length:0] lim2;
    logic [Count_length:0] lim_m1;

    // Coarse is in half-cycles, so anything at or beyond two half-cycles per period is saturated.
    always_comb begin
        ld_coarse = shadow[Dc_length-1:DE_bits];
        ld_fine   = shadow[DE_bits-1:0];
        lim2      = {period_next, 1'b0};
        lim_m1    = lim2 - WIDE_ONE;
        if ({1'b0, ld_coarse} >= lim2) begin
            ld_coarse = lim_m1[Count_length] ? '1 : lim_m1[Count_length-1:0];
            ld_fine   = '1;
        end
    end
`else
    logic period_unused;
    assign period_unused = ^period_next;

    always_comb begin
        ld_coarse = shadow[Dc_length-1:DE_bits];
        ld_fine   = shadow[DE_bits-1:0];
    end
`endif

    // A boundary load has priority; an accept is only possible while empty, so the two never collide.
    always_ff @(posedge clk_base) begin
        if (rst) begin
            dc_ready  <= 1'b1;
            shadow    <= '0;
            Dc_coarse <= '0;
            Dc_fine   <= '0;
        end else if (load && !dc_ready) begin
            Dc_coarse <= ld_coarse;
            Dc_fine   <= ld_fine;
            dc_ready  <= 1'b1;
        end else if (dc_valid && dc_ready) begin
            shadow   <= Dc_in;
            dc_ready <= 1'b0;
        end
    end

endmodule

// File: rtl/dpwm_period_ctrl.sv
// DPWM period controller: IDLE/RUN FSM, period counter and end-of-period marker; duty held in dpwm_duty_shadow.
// Optional duty clamp is enabled by defining DPWM_DUTY_CLAMP_EN.
module dpwm_period_ctrl
    import dpwm_period_ctrl_pkg::*;
#(
    parameter int DE_bits      = DEF_DE_BITS,
    parameter int Dc_length    = DEF_DC_LENGTH,
    parameter int Count_length = Dc_length - DE_bits
) (
    input  logic                    clk_base,
    input  logic                    rst,
    input  logic                    en,
    input  logic [Dc_length-1:0]    Dc_in,
    input  logic                    dc_valid,
    output logic                    dc_ready,
    input  logic [Count_length-1:0] period_cfg,
    output logic                    L_DPWM,
    output logic [Count_length-1:0] Dc_coarse,
    output logic [DE_bits-1:0]      Dc_fine,
    output logic                    period_start,
    output logic                    active
);

    localparam logic [Count_length-1:0] CNT_ONE = Count_length'(1);
    localparam logic [Count_length-1:0] CNT_TWO = Count_length'(2);

    state_t                  state;
    logic [Count_length-1:0] cnt;
    logic [Count_length-1:0] period_act;
    logic [Count_length-1:0] cfg_sat;
    logic                    at_end;
    logic                    load;

    assign cfg_sat = (period_cfg < CNT_TWO) ? CNT_TWO : period_cfg;
    assign at_end  = (state == RUN) && (cnt == period_act - CNT_ONE);
    // en is only looked at on entry and at boundaries, so a dropped en that returns in time is never seen.
    assign load    = en && ((state == IDLE) || at_end);

    always_ff @(posedge clk_base) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            period_act   <= CNT_TWO;
            L_DPWM       <= 1'b0;
            period_start <= 1'b0;
            active       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    L_DPWM <= 1'b0;
                    cnt    <= '0;
                    if (en) begin
                        state        <= RUN;
                        period_act   <= cfg_sat;
                        period_start <= 1'b1;
                        active       <= 1'b1;
                    end else begin
                        period_start <= 1'b0;
                        active       <= 1'b0;
                    end
                end
                RUN: begin
                    if (at_end) begin
                        cnt    <= '0;
                        L_DPWM <= 1'b0;
                        if (en) begin
                            period_act   <= cfg_sat;
                            period_start <= 1'b1;
                            active       <= 1'b1;
                        end else begin
                            state        <= IDLE;
                            period_start <= 1'b0;
                            active       <= 1'b0;
                        end
                    end else begin
                        cnt          <= cnt + CNT_ONE;
                        period_start <= 1'b0;
                        active       <= 1'b1;
                        L_DPWM       <= (cnt + CNT_ONE == period_act - CNT_ONE);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    dpwm_duty_shadow #(
        .DE_bits      (DE_bits),
        .Dc_length    (Dc_length),
        .Count_length (Count_length)
    ) u_duty_shadow (
        .clk_base    (clk_base),
        .rst         (rst),
        .Dc_in       (Dc_in),
        .dc_valid    (dc_valid),
        .dc_ready    (dc_ready),
        .load        (load),
        .period_next (cfg_sat),
        .Dc_coarse   (Dc_coarse),
        .Dc_fine     (Dc_fine)
    );

endmodule

// File: tb/tb_dpwm_period_ctrl.sv
// Bench for dpwm_period_ctrl: directed vector table, hand-written corner sequences, random run against a reference model.
module tb_dpwm_period_ctrl;

    localparam int DE = 6;
    localparam int DL = 13;
    localparam int CL = DL - DE;

    logic          clk_base = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [DL-1:0] Dc_in = '0;
    logic          dc_valid = 1'b0;
    logic          dc_ready;
    logic [CL-1:0] period_cfg = '0;
    logic          L_DPWM;
    logic [CL-1:0] Dc_coarse;
    logic [DE-1:0] Dc_fine;
    logic          period_start;
    logic          active;

    always #5 clk_base = ~clk_base;

    dpwm_period_ctrl #(.DE_bits(DE), .Dc_length(DL), .Count_length(CL)) dut (
        .clk_base     (clk_base),
        .rst          (rst),
        .en           (en),
        .Dc_in        (Dc_in),
        .dc_valid     (dc_valid),
        .dc_ready     (dc_ready),
        .period_cfg   (period_cfg),
        .L_DPWM       (L_DPWM),
        .Dc_coarse    (Dc_coarse),
        .Dc_fine      (Dc_fine),
        .period_start (period_start),
        .active       (active)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: period position, latched period, shadow contents and applied duty as plain integers.
    bit m_run, m_full, chk_model;
    int m_cnt, m_per, m_sh, m_co, m_fi;

    task automatic model_step(input bit r, input bit e, input bit v, input int dc, input int cfg);
        bit acc, ld;
        int lim;
        acc = v && !m_full;
        ld  = 1'b0;
        if (r) begin
            m_run = 0; m_cnt = 0; m_per = 2; m_full = 0; m_sh = 0; m_co = 0; m_fi = 0;
            return;
        end
        if (!m_run) begin
            if (e) begin
                m_run = 1; m_cnt = 0; m_per = (cfg < 2) ? 2 : cfg; ld = 1;
            end
        end else if (m_cnt == m_per - 1) begin
            m_cnt = 0;
            if (e) begin
                m_per = (cfg < 2) ? 2 : cfg; ld = 1;
            end else begin
                m_run = 0;
            end
        end else begin
            m_cnt = m_cnt + 1;
        end
        if (ld && m_full) begin
            m_co = m_sh / (1 << DE);
            m_fi = m_sh % (1 << DE);
`ifdef DPWM_DUTY_CLAMP_EN
            lim = 2 * m_per;
            if (m_co >= lim) begin
                m_co = (lim - 1 > (1 << CL) - 1) ? (1 << CL) - 1 : lim - 1;
                m_fi = (1 << DE) - 1;
            end
`else
            lim = 0;
`endif
            m_full = 0;
        end else if (acc) begin
            m_sh = dc; m_full = 1;
        end
    endtask

    task automatic cycle(input bit r, input bit e, input bit v, input int dc, input int cfg);
        rst = r; en = e; dc_valid = v; Dc_in = dc[DL-1:0]; period_cfg = cfg[CL-1:0];
        @(posedge clk_base);
        #1;
        model_step(r, e, v, dc, cfg);
        if (chk_model) begin
            check("model_L_DPWM", L_DPWM, (m_run && m_cnt == m_per - 1) ? 1 : 0);
            check("model_period_start", period_start, (m_run && m_cnt == 0) ? 1 : 0);
            check("model_active", active, m_run);
            check("model_dc_ready", dc_ready, !m_full);
            check("model_Dc_coarse", Dc_coarse, m_co);
            check("model_Dc_fine", Dc_fine, m_fi);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_L_DPWM"}, L_DPWM, 0);
        check({tag, "_period_start"}, period_start, 0);
        check({tag, "_active"}, active, 0);
        check({tag, "_Dc_coarse"}, Dc_coarse, 0);
        check({tag, "_Dc_fine"}, Dc_fine, 0);
        check({tag, "_dc_ready"}, dc_ready, 1);
    endtask

    typedef struct {
        bit en;
        bit v;
        int dc;
        bit L;
        bit ps;
        bit act;
        int co;
        int fi;
        bit rdy;
    } vec_t;

    vec_t vt[$];

    function automatic void add(bit e, bit v, int dc, bit l, bit ps, bit act, int co, int fi, bit rdy);
        vec_t x;
        x.en = e; x.v = v; x.dc = dc; x.L = l; x.ps = ps; x.act = act; x.co = co; x.fi = fi; x.rdy = rdy;
        vt.push_back(x);
    endfunction

    initial begin
        int exp_clamp_co;
        bit r, e, v;
        chk_model = 0;

        // 0x0A5 -> coarse 2, fine 0x25; 0x1C0 -> coarse 7, fine 0
        add(0, 1, 'h0A5, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 2, 'h25, 1);
        for (int c = 1; c <= 9; c++) add(1, 0, 0, c == 9, 0, 1, 2, 'h25, 1);
        add(1, 0, 0, 0, 1, 1, 2, 'h25, 1);
        add(1, 1, 'h1C0, 0, 0, 1, 2, 'h25, 0);
        for (int c = 2; c <= 9; c++) add(1, 0, 0, c == 9, 0, 1, 2, 'h25, 0);
        add(1, 0, 0, 0, 1, 1, 7, 0, 1);
        for (int c = 1; c <= 4; c++) add(1, 0, 0, 0, 0, 1, 7, 0, 1);
        for (int c = 5; c <= 9; c++) add(0, 0, 0, c == 9, 0, 1, 7, 0, 1);
        add(0, 0, 0, 0, 0, 0, 7, 0, 1);
        add(0, 0, 0, 0, 0, 0, 7, 0, 1);

        cycle(1, 0, 0, 0, 10);
        check_reset_values("reset");

        foreach (vt[i]) begin
            cycle(0, vt[i].en, vt[i].v, vt[i].dc, 10);
            check($sformatf("vec%0d_L_DPWM", i), L_DPWM, vt[i].L);
            check($sformatf("vec%0d_period_start", i), period_start, vt[i].ps);
            check($sformatf("vec%0d_active", i), active, vt[i].act);
            check($sformatf("vec%0d_Dc_coarse", i), Dc_coarse, vt[i].co);
            check($sformatf("vec%0d_Dc_fine", i), Dc_fine, vt[i].fi);
            check($sformatf("vec%0d_dc_ready", i), dc_ready, vt[i].rdy);
        end

        // period_cfg below 2 runs as a two-cycle period
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 0, 0, 1);
            check($sformatf("cfg1_L_DPWM_%0d", i), L_DPWM, i % 2);
            check($sformatf("cfg1_period_start_%0d", i), period_start, (i % 2) == 0);
        end

        // reset mid-period with a full shadow and every other input active
        cycle(1, 0, 0, 0, 10);
        cycle(0, 1, 0, 0, 10);
        cycle(0, 1, 1, 'h155, 10);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 10);
        check("midrst_pre_active", active, 1);
        check("midrst_pre_dc_ready", dc_ready, 0);
        cycle(1, 1, 1, 'h1FFF, 10);
        check_reset_values("midrst");
        cycle(0, 0, 0, 0, 10);
        check("midrst_after_active", active, 0);
        check("midrst_after_dc_ready", dc_ready, 1);

`ifdef DPWM_DUTY_CLAMP_EN
        exp_clamp_co = 19;
`else
        exp_clamp_co = 127;
`endif
        cycle(0, 0, 1, 'h1FFF, 10);
        cycle(0, 1, 0, 0, 10);
        check("clamp_Dc_coarse", Dc_coarse, exp_clamp_co);
        check("clamp_Dc_fine", Dc_fine, 'h3F);
        check("clamp_period_start", period_start, 1);

        // random phase, every cycle compared against the model
        cycle(1, 0, 0, 0, 10);
        chk_model = 1;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 3) == 0);
            cycle(r, e, v, $urandom_range(0, 8191), $urandom_range(0, 12));
        end
        chk_model = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
